axi_lite_i2c_regif: RTL and testbench

AXI4-Lite slave register front-end that sits directly upstream of the I2C master/slave top. It captures software-programmed slave address, register address, write data and operation type, and issues a one-cycle I2C_trigger. It then tracks the transaction until done, latching read data, ack error and timeout into status registers. It also raises an interrupt.

---
 rtl/axi_lite_i2c_regif_if.sv | 39 +++
 rtl/axi_lite_i2c_regif.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_lite_i2c_regif.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_i2c_regif_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_i2c_regif_if
// Purpose  : AXI4-Lite bus bundle between a bus master and the I2C register
//            front-end; the slave modport is used by the register block.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_i2c_regif_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_i2c_regif.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_i2c_regif
// Purpose  : AXI4-Lite register front-end for an I2C master/slave core.
//            Software programs the command, starts a transfer, and the block
//            issues a one-cycle trigger, then tracks completion/timeout into
//            sticky status flags and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_i2c_regif #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES     = 100000
) (
  input  logic                      clk,
  input  logic                      resetn,
  axi_lite_i2c_regif_if.slave       s_axi,
  output logic [7:0]                addr,
  output logic [7:0]                din,
  output logic [6:0]                slv_addr,
  output logic                      op_type,
  output logic                      I2C_trigger,
  input  logic [7:0]                dout,
  input  logic                      busy,
  input  logic                      ack_err,
  input  logic                      done,
  output logic                      irq
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_TRIG      = 2'd1;
  localparam logic [1:0] S_WAIT      = 2'd2;

  localparam logic [2:0] A_CTRL      = 3'd0;
  localparam logic [2:0] A_CMD       = 3'd1;
  localparam logic [2:0] A_TX        = 3'd2;
  localparam logic [2:0] A_RX        = 3'd3;
  localparam logic [2:0] A_STAT      = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // FSM
  logic [1:0]  state_q, state_d;
  logic        trig_d;

  // write channel
  logic                          awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]                    bresp_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          aw_hs, w_hs, wr_fire;
  logic                          aw_held_d, w_held_d, bvalid_d;

  // read channel
  logic        arready_q, rvalid_q, ar_hs, rvalid_d;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q, rd_data_d;
  logic        rd_err_d;

  // software-visible registers and flags
  logic        irq_en_q;
  logic [15:0] cmd_q;
  logic [7:0]  tx_q, rx_q;
  logic        done_flag_q, ack_flag_q, tmo_flag_q, rej_flag_q;
  logic        irq_q;

  // downstream shadow registers
  logic [7:0]  addr_q, din_q;
  logic [6:0]  slv_q;
  logic        op_q;

  logic [31:0] cnt_q;

  logic [2:0]  wr_sel;
  logic        wr_mapped, start_req, launch, timeout_hit;
  logic        set_done, set_ack, set_tmo, set_rej;
  logic [3:0]  w1c;
  logic        unused_ok;

  assign aw_hs     = s_axi.awvalid & awready_q;
  assign w_hs      = s_axi.wvalid & wready_q;
  // Readies stay low while a half is held or a response is pending, so both
  // halves being held means the response slot is free.
  assign wr_fire   = aw_held_q & w_held_q;
  assign aw_held_d = wr_fire ? 1'b0 : (aw_held_q | aw_hs);
  assign w_held_d  = wr_fire ? 1'b0 : (w_held_q | w_hs);
  assign bvalid_d  = wr_fire ? 1'b1 : (bvalid_q & ~s_axi.bready);

  assign ar_hs     = s_axi.arvalid & arready_q;
  assign rvalid_d  = ar_hs ? 1'b1 : (rvalid_q & ~s_axi.rready);

  assign wr_sel    = awaddr_q[4:2];
  assign wr_mapped = (wr_sel <= A_STAT);
  assign start_req = wr_fire & (wr_sel == A_CTRL) & wstrb_q[0] & wdata_q[0];
  assign launch    = start_req & (state_q == S_IDLE);
  assign w1c       = (wr_fire && wr_sel == A_STAT && wstrb_q[0]) ? wdata_q[4:1] : 4'b0000;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !done &&
                       (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign set_done  = (state_q == S_WAIT) & done;
  assign set_ack   = set_done & ack_err;
  assign set_tmo   = timeout_hit;
  assign set_rej   = start_req & (state_q != S_IDLE);

  assign unused_ok = ^{awaddr_q[1:0], s_axi.araddr[1:0], wdata_q[31:16], wstrb_q[3:2]};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign addr        = addr_q;
  assign din         = din_q;
  assign slv_addr    = slv_q;
  assign op_type     = op_q;
  assign I2C_trigger = trig_d;
  assign irq         = irq_q;

  // Write channel: capture AW and W independently, then issue the response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (wr_fire) bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read data mux for the register selected by the read address
  always_comb begin
    rd_data_d = 32'h0;
    rd_err_d  = 1'b0;
    case (s_axi.araddr[4:2])
      A_CTRL:  rd_data_d = {30'h0, irq_en_q, 1'b0};
      A_CMD:   rd_data_d = {16'h0, cmd_q};
      A_TX:    rd_data_d = {24'h0, tx_q};
      A_RX:    rd_data_d = {24'h0, rx_q};
      A_STAT:  rd_data_d = {26'h0, busy, rej_flag_q, tmo_flag_q, ack_flag_q,
                            done_flag_q, (state_q != S_IDLE)};
      default: rd_err_d  = 1'b1;
    endcase
  end

  // Read channel: register data at AR acceptance, hold until rready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'h0;
    end else begin
      arready_q <= ~rvalid_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_data_d;
        rresp_q <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Software registers and sticky status flags; a hardware set beats W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q    <= 1'b0;
      cmd_q       <= 16'h0;
      tx_q        <= 8'h0;
      rx_q        <= 8'h0;
      done_flag_q <= 1'b0;
      ack_flag_q  <= 1'b0;
      tmo_flag_q  <= 1'b0;
      rej_flag_q  <= 1'b0;
    end else begin
      if (wr_fire && wr_sel == A_CTRL && wstrb_q[0]) irq_en_q <= wdata_q[1];
      if (wr_fire && wr_sel == A_CMD && wstrb_q[0]) cmd_q[7:0]  <= wdata_q[7:0];
      if (wr_fire && wr_sel == A_CMD && wstrb_q[1]) cmd_q[15:8] <= wdata_q[15:8];
      if (wr_fire && wr_sel == A_TX && wstrb_q[0])  tx_q        <= wdata_q[7:0];
      if (set_done && op_q) rx_q <= dout;
      done_flag_q <= set_done | (done_flag_q & ~w1c[0]);
      ack_flag_q  <= set_ack  | (ack_flag_q  & ~w1c[1]);
      tmo_flag_q  <= set_tmo  | (tmo_flag_q  & ~w1c[2]);
      rej_flag_q  <= set_rej  | (rej_flag_q  & ~w1c[3]);
    end
  end

  // Registered interrupt from the enabled completion flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_q <= 1'b0;
    else         irq_q <= irq_en_q & (done_flag_q | ack_flag_q | tmo_flag_q);
  end

  // Shadow the command at launch so later CMD/TXDATA writes cannot disturb a transfer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= 8'h0;
      din_q  <= 8'h0;
      slv_q  <= 7'h0;
      op_q   <= 1'b0;
    end else if (launch) begin
      addr_q <= cmd_q[7:0];
      slv_q  <= cmd_q[14:8];
      op_q   <= cmd_q[15];
      din_q  <= tx_q;
    end
  end

  // Timeout counter: cleared in TRIG, counts each WAIT cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 cnt_q <= 32'h0;
    else if (state_q == S_TRIG)  cnt_q <= 32'h0;
    else if (state_q == S_WAIT)  cnt_q <= cnt_q + 32'h1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_TRIG;
      S_TRIG:  state_d = S_WAIT;
      S_WAIT:  if (done || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: trigger pulse is the single TRIG cycle
  always_comb begin
    trig_d = 1'b0;
    if (state_q == S_TRIG) trig_d = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_i2c_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_i2c_regif
// Purpose  : Directed self-checking bench for axi_lite_i2c_regif with a
//            hand-driven downstream I2C model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_i2c_regif;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_CMD  = 5'h04;
  localparam logic [4:0] A_TX   = 5'h08;
  localparam logic [4:0] A_RX   = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_i2c_regif_if #(.ADDR_W(5)) bus ();

  logic [7:0] addr, din, dout;
  logic [6:0] slv_addr;
  logic       op_type, I2C_trigger, busy, ack_err, done, irq;

  axi_lite_i2c_regif #(
    .C_S_AXI_ADDR_WIDTH (5),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_axi       (bus),
    .addr        (addr),
    .din         (din),
    .slv_addr    (slv_addr),
    .op_type     (op_type),
    .I2C_trigger (I2C_trigger),
    .dout        (dout),
    .busy        (busy),
    .ack_err     (ack_err),
    .done        (done),
    .irq         (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // cycle-stamped monitor of trigger pulses and irq rising edges
  int   cyc = 0, trig_count = 0, trig_cyc = 0, irq_rise_cyc = 0;
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (I2C_trigger) begin
      trig_count <= trig_count + 1;
      trig_cyc   <= cyc;
    end
    if (irq && !irq_prev) irq_rise_cyc <= cyc;
    irq_prev <= irq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   n = 0;
    logic haw, hw;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      haw = bus.awvalid & bus.awready;
      hw  = bus.wvalid & bus.wready;
      @(negedge clk); n++;
      if (haw) bus.awvalid = 1'b0;
      if (hw)  bus.wvalid  = 1'b0;
    end
    while (!bus.bvalid && n < 50) begin
      @(negedge clk); n++;
    end
    check("wr_bound", 32'(n < 50), 32'd1);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!bus.arready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk); n++;
    end
    check("rd_bound", 32'(n < 50), 32'd1);
    d    = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, exp);
  endtask

  task automatic pulse_done(input logic [7:0] dv, input logic ae);
    @(negedge clk);
    done = 1'b1; dout = dv; ack_err = ae;
    @(negedge clk);
    done = 1'b0; ack_err = 1'b0;
  endtask

  int          t0, n;
  logic        haw, hw, held;
  logic [31:0] rd;
  logic [1:0]  rr;

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    dout = 8'h00; busy = 1'b0; ack_err = 1'b0; done = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_axi", 32'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                          bus.bresp, bus.rresp}), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_out", 32'({addr, din, slv_addr, op_type, I2C_trigger, irq}), 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk("rst_status", A_STAT, 32'h0);

    // read transaction: slv 0x52, reg 0x34
    wr(A_CMD, 32'h0000_D234);
    t0 = trig_count;
    wr(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    check("t1_trig", 32'(trig_count - t0), 32'd1);
    check("t1_slv", 32'(slv_addr), 32'h52);
    check("t1_addr", 32'(addr), 32'h34);
    check("t1_op", 32'(op_type), 32'h1);
    pulse_done(8'hA5, 1'b0);
    check("t1_irq_lat", 32'(irq), 32'h0);
    @(negedge clk);
    check("t1_irq", 32'(irq), 32'h1);
    rd_chk("t1_rx", A_RX, 32'hA5);
    rd_chk("t1_status", A_STAT, 32'h02);
    rd_chk("t1_ctrl", A_CTRL, 32'h2);
    busy = 1'b1;
    rd_chk("t1_busy_mirror", A_STAT, 32'h22);
    busy = 1'b0;

    // write transaction with ack error
    wr(A_STAT, 32'h1E);
    wr(A_TX, 32'h5C);
    wr(A_CMD, 32'h0000_5234);
    t0 = trig_count;
    wr(A_CTRL, 32'h3);
    repeat (3) @(negedge clk);
    check("t2_trig", 32'(trig_count - t0), 32'd1);
    check("t2_din", 32'(din), 32'h5C);
    check("t2_op", 32'(op_type), 32'h0);
    pulse_done(8'h99, 1'b1);
    rd_chk("t2_status", A_STAT, 32'h06);
    check("t2_irq_set", 32'(irq), 32'h1);
    wr(A_STAT, 32'h06);
    repeat (2) @(negedge clk);
    check("t2_irq_clr", 32'(irq), 32'h0);
    rd_chk("t2_status_clr", A_STAT, 32'h0);
    rd_chk("t2_rx_keep", A_RX, 32'hA5);

    // START while busy is rejected; CMD rewrite does not disturb the shadow
    t0 = trig_count;
    wr(A_CTRL, 32'h3);
    wr(A_CMD, 32'h0000_1111);
    wr(A_CTRL, 32'h3);
    check("t3_one_trig", 32'(trig_count - t0), 32'd1);
    check("t3_slv_keep", 32'(slv_addr), 32'h52);
    pulse_done(8'h00, 1'b0);
    rd_chk("t3_status", A_STAT, 32'h12);
    wr(A_STAT, 32'h1E);
    repeat (2) @(negedge clk);

    // timeout: flag after 16 WAIT cycles, irq registered one cycle later
    wr(A_CTRL, 32'h3);
    repeat (30) @(negedge clk);
    check("t4_tmo_cycles", 32'(irq_rise_cyc - trig_cyc), 32'd18);
    rd_chk("t4_status", A_STAT, 32'h08);
    rd_chk("t4_rx_keep", A_RX, 32'hA5);
    wr(A_STAT, 32'h08);
    t0 = trig_count;
    wr(A_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    check("t4_restart", 32'(trig_count - t0), 32'd1);
    check("t4_new_slv", 32'(slv_addr), 32'h11);
    pulse_done(8'h00, 1'b0);
    wr(A_STAT, 32'h1E);

    // AXI protocol: W three cycles ahead of AW, bready held off for 5 cycles
    @(negedge clk);
    bus.wdata = 32'h0000_00C3; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    n = 0;
    while ((bus.awvalid || bus.wvalid || n < 3) && n < 50) begin
      haw = bus.awvalid & bus.awready;
      hw  = bus.wvalid & bus.wready;
      @(negedge clk); n++;
      if (haw) bus.awvalid = 1'b0;
      if (hw)  bus.wvalid  = 1'b0;
      if (n == 3) begin
        bus.awaddr = A_TX; bus.awvalid = 1'b1;
      end
    end
    while (!bus.bvalid && n < 50) begin
      @(negedge clk); n++;
    end
    check("t5_bound", 32'(n < 50), 32'd1);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      held = held & bus.bvalid & ~bus.awready & ~bus.wready;
      @(negedge clk);
    end
    check("t5_b_hold", 32'(held), 32'd1);
    check("t5_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t5_b_drop", 32'(bus.bvalid), 32'd0);
    rd_chk("t5_tx", A_TX, 32'hC3);
    axi_write(A_CMD, 32'h0000_7F99, 4'b0010, rr);
    rd_chk("t5_wstrb", A_CMD, 32'h7F11);
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, rr);
    check("t5_wr_slverr", 32'(rr), 32'h2);
    axi_read(5'h18, rd, rr);
    check("t5_rd_unmapped", rd, 32'h0);
    check("t5_rd_slverr", 32'(rr), 32'h2);

    // asynchronous reset during WAIT
    wr(A_CMD, 32'h0000_D234);
    wr(A_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    check("t6_pre", 32'({slv_addr, addr, op_type}), 32'({7'h52, 8'h34, 1'b1}));
    #2 resetn = 1'b0;
    #1;
    check("t6_async_out", 32'({addr, din, slv_addr, op_type, I2C_trigger, irq}), 32'h0);
    check("t6_async_axi", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    rd_chk("t6_status", A_STAT, 32'h0);
    rd_chk("t6_rx", A_RX, 32'h0);
    check("t6_irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
